opfetch: RTL and testbench
==========================

OPFETCH -- requirements
Module: opfetch

Interface
REQ-001 Parameter: ZERO_REGS, default 1, meaning: 1 = all 32 registers cleared by reset; 0 = register contents not reset.
REQ-002 clk  in  1  sole clock; all state updates on rising edge.
REQ-003 rst  in  1  synchronous, active-high reset.
REQ-004 opfetch__in_valid  in  1  decode presents an instruction.
REQ-005 opfetch__in_ready  out  1  stage accepts; transfer when in_valid & in_ready.
REQ-006 opfetch__in_rs, opfetch__in_rt, opfetch__in_rd  in  5 each  left source, right source, destination register index.
REQ-007 opfetch__in_imm  in  32  immediate; opfetch__in_use_imm  in  1  right operand = imm instead of rt.
REQ-008 opfetch__in_op  in  5  ALU opcode, passed through unmodified.
REQ-009 opfetch__out_valid  out  1; opfetch__out_ready  in  1; transfer when both high.
REQ-010 opfetch__alu_left, opfetch__alu_right  out  32; opfetch__alu_op  out  5; opfetch__out_rd  out  5; these drive the ALU's left/right/op inputs.
REQ-011 wb__valid  in  1; wb__rd  in  5; wb__data  in  32  writeback of ALU result.

Function
REQ-012 The block SHALL hold a 32x32 register file; reads of r0 SHALL return 0, and writes to r0 SHALL be ignored.
REQ-013 A register read SHALL return wb__data when wb__valid is high and wb__rd equals the read index (nonzero) in the same cycle (write-through bypass).
REQ-014 The scoreboard SHALL be 32 pending bits, one per register; r0 is never pending.
REQ-015 The hazard signal SHALL be high when in_rs is pending, or when in_rt is pending and in_use_imm=0, or when in_rd is nonzero and pending (WAW). A pending bit cleared by wb in the same cycle SHALL count as not pending.
REQ-016 opfetch__in_ready SHALL equal (!out_valid | out_ready) & !hazard & !rst.
REQ-017 On accept, the output register SHALL capture left=read(rs), right = use_imm ? imm : read(rt), op, rd, and set out_valid on the next edge; latency is exactly 1 cycle.
REQ-018 On accept with in_rd≠0, pending[in_rd] SHALL be set. When wb__valid and wb__rd≠0, pending[wb__rd] SHALL be cleared. If both target the same register in one cycle, set SHALL win.
REQ-019 When out_valid & !out_ready, all out_* signals SHALL hold stable.
REQ-020 out_valid SHALL clear after a consumed output unless a new accept occurs in the same cycle; a same-cycle consume and accept SHALL be allowed (full throughput: 1/cycle).
REQ-021 wb__valid with wb__rd not pending SHALL still write the register file.

Reset
REQ-022 While rst is high: out_valid=0, in_ready=0, all pending bits=0, out_* data=0, and registers=0 if ZERO_REGS=1. Writeback is ignored during reset.
REQ-023 Reset asserted while an output is stalled SHALL drop it; no transfer is reported.

Structure
REQ-024 The register index width (5), data width (32) and op width (5) SHALL be constants in the shared CPU include alongside the ALU opcode defines.
REQ-025 The register file (2 read ports, 1 write port, bypass) SHALL be a sub-module named opfetch_regfile; the scoreboard and output register stay in opfetch.

Verification
REQ-026 Write r3=0x0000_0005 via wb; issue rs=3, rt=0, use_imm=0, op=ADD, rd=4 -> next cycle left=5, right=0, op=ADD, out_rd=4, pending[4]=1.
REQ-027 With r4 pending, issue rs=4 -> in_ready=0 until wb__rd=4, data=0x1234; in that wb cycle in_ready=1, and the captured left=0x1234.
REQ-028 Issue use_imm=1, imm=0xFFFF_FFFF, rt=7 with r7 pending -> no stall; right=0xFFFF_FFFF.
REQ-029 Hold out_ready=0 for 3 cycles after a valid output -> outputs unchanged, in_ready=0; release -> back-to-back issues at 1/cycle.
REQ-030 Issue rd=0 and write wb__rd=0, data=0xDEAD -> r0 reads 0; pending never set.
REQ-031 Assert rst mid-stall with r5 pending -> next cycle out_valid=0, pending[5]=0, and an issue with rs=5 is accepted immediately after reset.

Source files
------------

// File: rtl/opfetch_pkg.sv
// Shared CPU constants for the operand-fetch stage.
// Holds register index / data / opcode widths, the ALU opcode encoding,
// and a helper that turns a register index into a scoreboard mask.
package opfetch_pkg;

    localparam int unsigned REG_W    = 5;
    localparam int unsigned DATA_W   = 32;
    localparam int unsigned OP_W     = 5;
    localparam int unsigned NUM_REGS = 32;

    typedef logic [REG_W-1:0]    reg_idx_t;
    typedef logic [DATA_W-1:0]   data_t;
    typedef logic [OP_W-1:0]     op_t;
    typedef logic [NUM_REGS-1:0] reg_mask_t;

    typedef enum logic [OP_W-1:0] {
        ALU_ADD  = 5'd0,
        ALU_SUB  = 5'd1,
        ALU_AND  = 5'd2,
        ALU_OR   = 5'd3,
        ALU_XOR  = 5'd4,
        ALU_SLL  = 5'd5,
        ALU_SRL  = 5'd6,
        ALU_SRA  = 5'd7,
        ALU_SLT  = 5'd8,
        ALU_SLTU = 5'd9
    } alu_op_e;

    // One-hot mask for a register; r0 maps to an empty mask so it can
    // never become pending.
    function automatic reg_mask_t reg_mask(input reg_idx_t idx);
        reg_mask = (idx == '0) ? '0 : (reg_mask_t'(1) << idx);
    endfunction

endpackage

// File: rtl/opfetch_if.sv
// Bus interfaces for the operand-fetch stage.
//   opfetch_if    : decode -> opfetch instruction handshake (in_*) and
//                   opfetch -> ALU operand handshake (out_* / alu_*).
//                   master = decode/ALU side, slave = opfetch.
//   opfetch_wb_if : ALU result writeback (valid, rd, data).
//                   master = writeback source, slave = opfetch.
interface opfetch_if;
    import opfetch_pkg::*;

    logic     in_valid;
    logic     in_ready;
    reg_idx_t in_rs;
    reg_idx_t in_rt;
    reg_idx_t in_rd;
    data_t    in_imm;
    logic     in_use_imm;
    op_t      in_op;

    logic     out_valid;
    logic     out_ready;
    data_t    alu_left;
    data_t    alu_right;
    op_t      alu_op;
    reg_idx_t out_rd;

    modport master (
        output in_valid, in_rs, in_rt, in_rd, in_imm, in_use_imm, in_op,
        input  in_ready,
        input  out_valid, alu_left, alu_right, alu_op, out_rd,
        output out_ready
    );

    modport slave (
        input  in_valid, in_rs, in_rt, in_rd, in_imm, in_use_imm, in_op,
        output in_ready,
        output out_valid, alu_left, alu_right, alu_op, out_rd,
        input  out_ready
    );
endinterface

interface opfetch_wb_if;
    import opfetch_pkg::*;

    logic     valid;
    reg_idx_t rd;
    data_t    data;

    modport master (output valid, rd, data);
    modport slave  (input  valid, rd, data);
endinterface

// File: rtl/opfetch_regfile.sv
// 32x32 register file with two read ports and one write port.
// Ports:
//   clk, rst          : clock, synchronous active-high reset
//   rs_idx / rs_data  : read port A
//   rt_idx / rt_data  : read port B
//   wr_en, wr_idx,
//   wr_data           : write port (writes to r0 are dropped)
// r0 always reads 0. A read of the register being written in the same
// cycle returns the write data (write-through bypass).
module opfetch_regfile
    import opfetch_pkg::*;
#(
    parameter int unsigned ZERO_REGS = 1
) (
    input  logic     clk,
    input  logic     rst,
    input  reg_idx_t rs_idx,
    output data_t    rs_data,
    input  reg_idx_t rt_idx,
    output data_t    rt_data,
    input  logic     wr_en,
    input  reg_idx_t wr_idx,
    input  data_t    wr_data
);

    data_t regs [NUM_REGS];

    always_ff @(posedge clk) begin
        if (rst) begin
            // Writes are ignored during reset whether or not contents clear.
            if (ZERO_REGS != 0) begin
                for (int unsigned i = 0; i < NUM_REGS; i++) begin
                    regs[i] <= '0;
                end
            end
        end else if (wr_en && wr_idx != '0) begin
            regs[wr_idx] <= wr_data;
        end
    end

    always_comb begin
        rs_data = regs[rs_idx];
        if (rs_idx == '0) begin
            rs_data = '0;
        end else if (wr_en && wr_idx == rs_idx) begin
            rs_data = wr_data;
        end
    end

    always_comb begin
        rt_data = regs[rt_idx];
        if (rt_idx == '0) begin
            rt_data = '0;
        end else if (wr_en && wr_idx == rt_idx) begin
            rt_data = wr_data;
        end
    end

endmodule

// File: rtl/opfetch.sv
// Operand-fetch pipeline stage.
// Accepts an instruction from decode, reads its operands from the
// register file (with writeback bypass), and presents them to the ALU
// through a one-entry output register. A 32-bit scoreboard marks
// registers with an outstanding result and stalls RAW/WAW hazards.
// Ports:
//   clk, rst : clock, synchronous active-high reset
//   fe       : opfetch_if.slave  (decode handshake in, ALU handshake out)
//   wb       : opfetch_wb_if.slave (ALU result writeback)
module opfetch
    import opfetch_pkg::*;
#(
    parameter int unsigned ZERO_REGS = 1
) (
    input logic          clk,
    input logic          rst,
    opfetch_if.slave     fe,
    opfetch_wb_if.slave  wb
);

    reg_mask_t pending;
    reg_mask_t pend_now;
    reg_mask_t clr_mask;
    reg_mask_t set_mask;
    logic      hazard;
    logic      in_ready;
    logic      accept;
    logic      wr_en;

    data_t     rs_data;
    data_t     rt_data;

    logic      valid_q;
    data_t     left_q;
    data_t     right_q;
    op_t       op_q;
    reg_idx_t  rd_q;

    assign wr_en = wb.valid & ~rst;

    opfetch_regfile #(
        .ZERO_REGS (ZERO_REGS)
    ) u_regfile (
        .clk     (clk),
        .rst     (rst),
        .rs_idx  (fe.in_rs),
        .rs_data (rs_data),
        .rt_idx  (fe.in_rt),
        .rt_data (rt_data),
        .wr_en   (wr_en),
        .wr_idx  (wb.rd),
        .wr_data (wb.data)
    );

    // A result arriving this cycle already resolves its hazard.
    always_comb begin
        clr_mask = '0;
        if (wb.valid) begin
            clr_mask = reg_mask(wb.rd);
        end
        pend_now = pending & ~clr_mask;
        hazard   = pend_now[fe.in_rs]
                 | (~fe.in_use_imm & pend_now[fe.in_rt])
                 | ((fe.in_rd != '0) & pend_now[fe.in_rd]);
    end

    assign in_ready = (~valid_q | fe.out_ready) & ~hazard & ~rst;
    assign accept   = fe.in_valid & in_ready;
    assign set_mask = accept ? reg_mask(fe.in_rd) : '0;

    // Set is applied after clear so a same-cycle issue to the register
    // being written back leaves it pending.
    always_ff @(posedge clk) begin
        if (rst) begin
            pending <= '0;
        end else begin
            pending <= (pending & ~clr_mask) | set_mask;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            valid_q <= 1'b0;
            left_q  <= '0;
            right_q <= '0;
            op_q    <= '0;
            rd_q    <= '0;
        end else if (accept) begin
            valid_q <= 1'b1;
            left_q  <= rs_data;
            right_q <= fe.in_use_imm ? fe.in_imm : rt_data;
            op_q    <= fe.in_op;
            rd_q    <= fe.in_rd;
        end else if (fe.out_ready) begin
            valid_q <= 1'b0;
        end
    end

    assign fe.in_ready  = in_ready;
    assign fe.out_valid = valid_q;
    assign fe.alu_left  = left_q;
    assign fe.alu_right = right_q;
    assign fe.alu_op    = op_q;
    assign fe.out_rd    = rd_q;

endmodule

// File: tb/tb_opfetch.sv
// Self-checking bench for opfetch: directed scenarios followed by
// randomized traffic, all checked against a behavioural model that
// tracks register values, outstanding results and the output slot.
module tb_opfetch;
    import opfetch_pkg::*;

    logic clk = 1'b0;
    logic rst;
    always #5 clk = ~clk;

    opfetch_if    fe ();
    opfetch_wb_if wb ();

    opfetch #(
        .ZERO_REGS (1)
    ) dut (
        .clk (clk),
        .rst (rst),
        .fe  (fe),
        .wb  (wb)
    );

    int total = 0;
    int bad   = 0;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s got=%h exp=%h", tag, got, exp);
        end
    endtask

    // Behavioural model state
    logic [31:0] m_regs [32];
    bit          m_pend [32];
    bit          m_valid;
    logic [31:0] m_left;
    logic [31:0] m_right;
    logic [4:0]  m_op;
    logic [4:0]  m_rd;

    function automatic bit busy(input logic [4:0] i);
        if (i == 0) return 1'b0;
        if (wb.valid && wb.rd == i) return 1'b0;
        return m_pend[i];
    endfunction

    function automatic logic [31:0] read_reg(input logic [4:0] i);
        if (i == 0) return 32'h0;
        if (wb.valid && wb.rd == i) return wb.data;
        return m_regs[i];
    endfunction

    function automatic logic [31:0] pend_vec();
        logic [31:0] v;
        for (int i = 0; i < 32; i++) v[i] = m_pend[i];
        return v;
    endfunction

    task automatic model_reset();
        for (int i = 0; i < 32; i++) begin
            m_regs[i] = 32'h0;
            m_pend[i] = 1'b0;
        end
        m_valid = 1'b0;
        m_left  = 32'h0;
        m_right = 32'h0;
        m_op    = 5'h0;
        m_rd    = 5'h0;
    endtask

    // One clock: check at the falling edge, advance the model, then let
    // the rising edge pass so the caller can drive the next cycle.
    task automatic tick();
        bit          stall;
        bit          rdy;
        bit          acc;
        logic [31:0] l;
        logic [31:0] r;
        @(negedge clk);
        stall = busy(fe.in_rs) || (!fe.in_use_imm && busy(fe.in_rt)) || busy(fe.in_rd);
        rdy   = (!m_valid || fe.out_ready) && !stall && !rst;
        check("in_ready",  {31'h0, fe.in_ready},  {31'h0, rdy});
        check("out_valid", {31'h0, fe.out_valid}, {31'h0, m_valid});
        check("alu_left",  fe.alu_left,  m_left);
        check("alu_right", fe.alu_right, m_right);
        check("alu_op",    {27'h0, fe.alu_op}, {27'h0, m_op});
        check("out_rd",    {27'h0, fe.out_rd}, {27'h0, m_rd});
        check("pending",   dut.pending, pend_vec());
        if (rst) begin
            model_reset();
        end else begin
            acc = fe.in_valid && rdy;
            l   = read_reg(fe.in_rs);
            r   = fe.in_use_imm ? fe.in_imm : read_reg(fe.in_rt);
            if (wb.valid && wb.rd != 0) begin
                m_regs[wb.rd] = wb.data;
                m_pend[wb.rd] = 1'b0;
            end
            if (acc) begin
                m_valid = 1'b1;
                m_left  = l;
                m_right = r;
                m_op    = fe.in_op;
                m_rd    = fe.in_rd;
                if (fe.in_rd != 0) m_pend[fe.in_rd] = 1'b1;
            end else if (fe.out_ready) begin
                m_valid = 1'b0;
            end
        end
        @(posedge clk);
        #1;
    endtask

    task automatic idle();
        rst           = 1'b0;
        fe.in_valid   = 1'b0;
        fe.in_rs      = '0;
        fe.in_rt      = '0;
        fe.in_rd      = '0;
        fe.in_imm     = '0;
        fe.in_use_imm = 1'b0;
        fe.in_op      = '0;
        fe.out_ready  = 1'b1;
        wb.valid      = 1'b0;
        wb.rd         = '0;
        wb.data       = '0;
    endtask

    task automatic issue(input logic [4:0] rs, input logic [4:0] rt, input logic [4:0] rd,
                         input logic [31:0] imm, input logic use_imm, input logic [4:0] op);
        fe.in_valid   = 1'b1;
        fe.in_rs      = rs;
        fe.in_rt      = rt;
        fe.in_rd      = rd;
        fe.in_imm     = imm;
        fe.in_use_imm = use_imm;
        fe.in_op      = op;
    endtask

    task automatic wback(input logic [4:0] rd, input logic [31:0] data);
        wb.valid = 1'b1;
        wb.rd    = rd;
        wb.data  = data;
    endtask

    initial begin
        model_reset();
        idle();
        rst = 1'b1;
        @(posedge clk);
        #1;
        tick();
        tick();
        rst = 1'b0;

        // Write r3 = 5, then issue r4 = r3 + r0
        idle(); wback(5'd3, 32'h5); tick();
        idle(); issue(5'd3, 5'd0, 5'd4, 32'h0, 1'b0, ALU_ADD); tick();
        check("r26_left",  fe.alu_left, 32'h5);
        check("r26_right", fe.alu_right, 32'h0);
        check("r26_op",    {27'h0, fe.alu_op}, {27'h0, ALU_ADD});
        check("r26_rd",    {27'h0, fe.out_rd}, 32'd4);
        check("r26_pend4", {31'h0, dut.pending[4]}, 32'h1);

        // RAW on r4 stalls until its writeback, which is bypassed
        idle(); issue(5'd4, 5'd0, 5'd6, 32'h0, 1'b0, ALU_SUB); tick(); tick();
        wback(5'd4, 32'h1234); tick();
        check("r27_left", fe.alu_left, 32'h1234);

        // Immediate operand ignores a pending rt
        idle(); issue(5'd0, 5'd0, 5'd7, 32'h0, 1'b0, ALU_OR); tick();
        idle(); issue(5'd1, 5'd7, 5'd8, 32'hFFFF_FFFF, 1'b1, ALU_XOR); tick();
        check("r28_valid", {31'h0, fe.out_valid}, 32'h1);
        check("r28_right", fe.alu_right, 32'hFFFF_FFFF);

        // Output stall for 3 cycles, then back-to-back issue
        idle(); issue(5'd2, 5'd0, 5'd9, 32'h0, 1'b0, ALU_AND); tick();
        issue(5'd2, 5'd0, 5'd10, 32'h0, 1'b0, ALU_SLL);
        fe.out_ready = 1'b0;
        repeat (3) tick();
        check("r29_hold_rd", {27'h0, fe.out_rd}, 32'd9);
        fe.out_ready = 1'b1;
        for (int i = 0; i < 4; i++) begin
            issue(5'd0, 5'd0, 5'(11 + i), 32'(i), 1'b1, ALU_ADD);
            tick();
            check("r29_b2b_rd", {27'h0, fe.out_rd}, 32'(11 + i));
        end

        // r0 destination and r0 writeback
        idle(); issue(5'd0, 5'd0, 5'd0, 32'h0, 1'b0, ALU_ADD); wback(5'd0, 32'hDEAD); tick();
        check("r30_left", fe.alu_left, 32'h0);
        check("r30_pend", dut.pending[0], 1'b0);

        // Reset during a stall drops the output and the scoreboard
        idle(); issue(5'd0, 5'd0, 5'd5, 32'h0, 1'b0, ALU_ADD); tick();
        issue(5'd0, 5'd0, 5'd15, 32'h0, 1'b0, ALU_ADD); fe.out_ready = 1'b0; tick();
        rst = 1'b1; tick();
        idle();
        check("r31_valid", {31'h0, fe.out_valid}, 32'h0);
        check("r31_pend5", {31'h0, dut.pending[5]}, 32'h0);
        issue(5'd5, 5'd0, 5'd16, 32'h0, 1'b0, ALU_ADD); tick();
        check("r31_accept", {31'h0, fe.out_valid}, 32'h1);

        // Randomized traffic over a small register window for frequent hazards
        for (int n = 0; n < 1500; n++) begin
            rst           = ($urandom_range(0, 99) == 0);
            fe.in_valid   = ($urandom_range(0, 9) < 7);
            fe.in_rs      = 5'($urandom_range(0, 7));
            fe.in_rt      = 5'($urandom_range(0, 7));
            fe.in_rd      = 5'($urandom_range(0, 7));
            fe.in_imm     = $urandom;
            fe.in_use_imm = 1'($urandom_range(0, 1));
            fe.in_op      = 5'($urandom_range(0, 31));
            fe.out_ready  = ($urandom_range(0, 9) < 7);
            wb.valid      = ($urandom_range(0, 9) < 4);
            wb.rd         = 5'($urandom_range(0, 7));
            wb.data       = $urandom;
            tick();
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
